// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state codes and default frame parameters
// Purpose: common definitions for the UART receiver and transmitter so both
//          report the same state encoding on their debug outputs.
// Ports:   none (package).
// Config:  UART_RX_PARITY_EN selects whether the PARITY state is reachable;
//          its code is reserved here regardless.
`timescale 1ns/1ps

package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_DONE   = 3'd4,
        ST_PARITY = 3'd5,
        ST_BREAK  = 3'd6
    } uart_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// rtl/uart_bit_sync.sv - two-flop synchronizer for an asynchronous serial line
// Purpose: brings rx_in into the clk_sys domain; resets to 1 so an idle-high
//          line never looks like a start bit while the flops fill.
// Ports:   clk_sys - system clock
//          rst     - synchronous active-high reset
//          din     - asynchronous input
//          dout    - synchronized output
`timescale 1ns/1ps

module uart_bit_sync (
    input  logic clk_sys,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling UART receiver with mid-bit sampling
// Purpose: receives start + DATA_BITS (LSB first) [+ even parity] + stop frames,
//          sampling each bit at its centre using a CLKS_PER_BIT baud counter.
// Ports:   clk_sys     - system clock, all logic on rising edge
//          rst         - synchronous active-high reset
//          rx_in       - asynchronous serial line, idle high
//          rx_data_out - last good received word, held between frames
//          rx_valid    - one-cycle pulse when rx_data_out is updated
//          frame_err   - one-cycle pulse when the stop bit is sampled low
//          rx_state    - current FSM state code (debug)
//          parity_err  - only with UART_RX_PARITY_EN: pulses with rx_valid on
//                        an even-parity mismatch
// Config:  define UART_RX_PARITY_EN to add the parity bit and parity_err.
`timescale 1ns/1ps

module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic [2:0]           rx_state
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [BW-1:0]        baud_cnt;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frame_err_q;
    logic                 baud_tick;
    logic                 half_tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    uart_bit_sync u_bit_sync (
        .clk_sys (clk_sys),
        .rst     (rst),
        .din     (rx_in),
        .dout    (rx_s)
    );

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign half_tick = (baud_cnt == BAUD_HALF);

    // State register
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a falling edge only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                // Line back high at start-bit centre: treat as a glitch
                if (half_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_tick) state_nxt = rx_s ? ST_DONE : ST_BREAK;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_BREAK: begin
                // Wait out a held-low line so it cannot start a frame
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Baud/bit counters, shift register and registered result flags
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data_out <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
`endif
        end else begin
            // Clear on every state entry so each phase times from its own start
            if ((state_nxt != state) || (state == ST_IDLE) || baud_tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end

            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if ((state == ST_DATA) && baud_tick) begin
                bit_cnt <= bit_cnt + CW'(1);
            end

            if ((state == ST_DATA) && baud_tick) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end

            // Load on the good stop sample so the new word is visible in DONE
            if ((state == ST_STOP) && baud_tick && rx_s) begin
                rx_data_out <= shift_reg;
            end

            frame_err_q <= (state == ST_STOP) && baud_tick && !rx_s;

`ifdef UART_RX_PARITY_EN
            if ((state == ST_PARITY) && baud_tick) begin
                par_bad <= ^{shift_reg, rx_s};
            end
`endif
        end
    end

    // Outputs
    always_comb begin
        rx_valid  = (state == ST_DONE);
        frame_err = frame_err_q;
        rx_state  = state;
`ifdef UART_RX_PARITY_EN
        parity_err = (state == ST_DONE) && par_bad;
`endif
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - directed scoreboard bench for uart_rx_oversample
// Build with or without UART_RX_PARITY_EN.
`timescale 1ns/1ps

module tb_uart_rx_oversample;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif

    logic          clk_sys = 1'b0;
    logic          rst     = 1'b1;
    logic          rx_in   = 1'b1;
    logic [DB-1:0] rx_data_out;
    logic          rx_valid;
    logic          frame_err;
    logic [2:0]    rx_state;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
    logic          bad_par = 1'b0;
`endif

    uart_rx_oversample #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .rx_state    (rx_state)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   vtimes[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   valid_count = 0;
    int   ferr_count  = 0;

    always @(posedge clk_sys) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard
    exp_t e;
    always @(negedge clk_sys) begin
        if (rx_valid) begin
            valid_count++;
            vtimes.push_back(cyc);
            check("valid_excl_ferr", {31'd0, frame_err}, 0);
            check("sb_has_entry", {31'd0, sb.size() > 0}, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rx_data", {24'd0, rx_data_out}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
            end
        end
        if (frame_err) ferr_count++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) check("parity_err_needs_valid", {31'd0, rx_valid}, 1);
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        drive_bit(stop_v);
    endtask

    initial begin
        int mask;

        // Reset state
        rst   = 1'b1;
        rx_in = 1'b1;
        tick(4);
        check("rst_data", {24'd0, rx_data_out}, 0);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_state", {29'd0, rx_state}, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", {31'd0, parity_err}, 0);
`endif
        rst = 1'b0;
        tick(20);

        // Good frame 0xA5
        sb.push_back('{8'hA5, 1'b0});
        send_frame(8'hA5, 1'b1);
        tick(20);
        check("a5_count", valid_count, 1);
        check("a5_ferr", ferr_count, 0);
        check("a5_state", {29'd0, rx_state}, 0);
        check("a5_data", {24'd0, rx_data_out}, 32'hA5);

        // 5-cycle glitch: START then back to IDLE, nothing else
        mask  = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) rx_in = 1'b1;
            tick(1);
            mask |= (1 << rx_state);
        end
        check("glitch_states", mask, 3);
        check("glitch_count", valid_count, 1);
        check("glitch_ferr", ferr_count, 0);
        check("glitch_data", {24'd0, rx_data_out}, 32'hA5);

        // 0x38 with low stop bit, line held low 40 cycles from stop-bit start
        send_frame(8'h38, 1'b0);
        check("brk_state", {29'd0, rx_state}, 6);
        check("brk_ferr_pulse", ferr_count, 1);
        tick(24);
        check("brk_hold", {29'd0, rx_state}, 6);
        rx_in = 1'b1;
        tick(10);
        check("brk_exit", {29'd0, rx_state}, 0);
        check("brk_data", {24'd0, rx_data_out}, 32'hA5);
        check("brk_count", valid_count, 1);
        check("brk_ferr_once", ferr_count, 1);
        tick(20);

        // Back-to-back frames, no idle gap
        sb.push_back('{8'h38, 1'b0});
        sb.push_back('{8'hC3, 1'b0});
        send_frame(8'h38, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(20);
        check("b2b_count", valid_count, 3);
        check("b2b_spacing", vtimes[2] - vtimes[1], FRAME_BITS * CPB);
        check("b2b_data", {24'd0, rx_data_out}, 32'hC3);

        // Reset for one cycle in the middle of bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        tick(8);
        rst = 1'b1;
        tick(1);
        check("mid_rst_data", {24'd0, rx_data_out}, 0);
        check("mid_rst_state", {29'd0, rx_state}, 0);
        check("mid_rst_valid", {31'd0, rx_valid}, 0);
        check("mid_rst_ferr", {31'd0, frame_err}, 0);
        rst = 1'b0;
        tick(8 + (FRAME_BITS - 5) * CPB + 20);
        check("mid_rst_count", valid_count, 3);
        check("mid_rst_ferr_cnt", ferr_count, 1);

        sb.push_back('{8'h5A, 1'b0});
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("post_rst_count", valid_count, 4);
        check("post_rst_data", {24'd0, rx_data_out}, 32'h5A);

`ifdef UART_RX_PARITY_EN
        // 0x07 with wrong parity bit 0, then correct parity bit 1
        bad_par = 1'b1;
        sb.push_back('{8'h07, 1'b1});
        send_frame(8'h07, 1'b1);
        tick(20);
        bad_par = 1'b0;
        sb.push_back('{8'h07, 1'b0});
        send_frame(8'h07, 1'b1);
        tick(20);
        check("par_count", valid_count, 6);
        check("par_data", {24'd0, rx_data_out}, 32'h07);
`endif

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
